// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ requesters.
// Each grant lasts up to MAX_BURST accepted words and never writes while full.
module fifo_wr_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int FIFO_DATAWIDTH = 16,
    parameter int MAX_BURST      = 4,
    localparam int OW            = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
    localparam int BW            = $clog2(MAX_BURST) + 1
) (
    input  logic                              wr_clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*FIFO_DATAWIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                ack,
    input  logic                              full,
    output logic                              wr_en,
    output logic [FIFO_DATAWIDTH-1:0]         din,
    output logic                              busy,
    output logic [OW-1:0]                     owner
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                                   state, state_nxt;
    logic [OW-1:0]                            last_owner, last_owner_nxt, owner_nxt;
    logic [BW-1:0]                            burst_cnt, burst_cnt_nxt;
    logic [OW-1:0]                            rr_idx, rr_pick;
    logic [NUM_REQ-1:0][FIFO_DATAWIDTH-1:0]   data_lane;

    assign data_lane = req_data;
    assign din       = data_lane[owner];
    assign busy      = (state == GRANT);
    assign wr_en     = busy && req[owner] && !full;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ack
        assign ack[i] = wr_en && (owner == OW'(i));
    end

    // Walk from farthest to nearest so the nearest set bit after last_owner wins.
    always_comb begin
        rr_idx  = '0;
        rr_pick = last_owner;
        for (int k = NUM_REQ; k >= 1; k--) begin
            rr_idx = OW'((int'(last_owner) + k) % NUM_REQ);
            if (req[rr_idx]) rr_pick = rr_idx;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        burst_cnt_nxt  = burst_cnt;
        case (state)
            IDLE: begin
                if (|req) begin
                    owner_nxt     = rr_pick;
                    burst_cnt_nxt = '0;
                    state_nxt     = GRANT;
                end
            end
            GRANT: begin
                if (wr_en) begin
                    if (burst_cnt == BW'(MAX_BURST - 1)) begin
                        last_owner_nxt = owner;
                        state_nxt      = IDLE;
                    end else begin
                        burst_cnt_nxt = burst_cnt + 1'b1;
                    end
                end else if (!req[owner]) begin
                    last_owner_nxt = owner;
                    state_nxt      = IDLE;
                end
                // req held with full high: stall, counter frozen
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= OW'(NUM_REQ - 1);
            burst_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            burst_cnt  <= burst_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, bursts, rotation, short request,
// full backpressure and reset mid-burst, with a write log captured at negedge.
module tb_fifo_wr_arbiter;

    logic        wr_clk;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] req_data;
    logic [3:0]  ack;
    logic        full;
    logic        wr_en;
    logic [15:0] din;
    logic        busy;
    logic [1:0]  owner;

    int checks   = 0;
    int failures = 0;
    int cnt [4];
    int ovf      = 0;
    logic [15:0] wq [$];
    int          oq [$];

    fifo_wr_arbiter #(.NUM_REQ(4), .FIFO_DATAWIDTH(16), .MAX_BURST(4)) dut (
        .wr_clk   (wr_clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .full     (full),
        .wr_en    (wr_en),
        .din      (din),
        .busy     (busy),
        .owner    (owner)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    function automatic logic [15:0] base(input int i);
        case (i)
            0:       return 16'h1000;
            1:       return 16'h2000;
            2:       return 16'hA000;
            default: return 16'h3000;
        endcase
    endfunction

    // Each requester presents base+n, advancing after every ack.
    always_comb begin
        req_data = '0;
        for (int i = 0; i < 4; i++) req_data[i*16 +: 16] = 16'(base(i) + 16'(cnt[i]));
    end

    always @(negedge wr_clk) begin
        if (wr_en) begin
            wq.push_back(din);
            oq.push_back(int'(owner));
            if (full) ovf <= ovf + 1;
        end
        for (int i = 0; i < 4; i++) if (ack[i]) cnt[i] <= cnt[i] + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int st;
        int sc [4];
        int nk [4];
        int o;
        rst = 1'b1; req = '0; full = 1'b0;

        // reset and idle
        repeat (10) @(posedge wr_clk);
        #2;
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_ack",   32'(ack),   0);
        chk("rst_busy",  32'(busy),  0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_din",   32'(din),   32'h1000);
        @(posedge wr_clk); #1 rst = 1'b0;
        for (int s = 0; s < 20; s++) begin
            @(posedge wr_clk); #2;
            chk("idle_wr_en", 32'(wr_en), 0);
            chk("idle_ack",   32'(ack),   0);
            chk("idle_busy",  32'(busy),  0);
            chk("idle_owner", 32'(owner), 0);
        end

        // single requester: 4 words, one idle bubble, 4 words
        st = wq.size();
        @(posedge wr_clk); #1 req = 4'b0100;
        for (int s = 1; s <= 10; s++) begin
            @(posedge wr_clk); #2;
            chk("single_wr_en", 32'(wr_en), (s % 5 != 0) ? 1 : 0);
            chk("single_ack",   32'(ack),   (s % 5 != 0) ? 32'b0100 : 0);
        end
        req = '0;
        @(posedge wr_clk); #2;
        chk("single_count", 32'(wq.size() - st), 8);
        for (int k = 0; k < 8; k++) chk("single_data", 32'(wq[st+k]), 32'h0000A000 + 32'(k));

        // round robin from reset priority: 0,1,2,3,0
        rst = 1'b1;
        @(posedge wr_clk); #1 rst = 1'b0;
        st = wq.size();
        for (int i = 0; i < 4; i++) begin sc[i] = cnt[i]; nk[i] = 0; end
        req = 4'b1111;
        for (int s = 1; s <= 25; s++) begin
            @(posedge wr_clk); #2;
            chk("rr_busy", 32'(busy), (s % 5 != 0) ? 1 : 0);
            if (s % 5 != 0) chk("rr_owner", 32'(owner), 32'(((s - 1) / 5) % 4));
        end
        req = '0;
        chk("rr_count", 32'(wq.size() - st), 20);
        for (int k = 0; k < 20 && st + k < wq.size(); k++) begin
            o = (k / 4) % 4;
            chk("rr_word_owner", 32'(oq[st+k]), 32'(o));
            chk("rr_word_data",  32'(wq[st+k]), 32'(16'(base(o) + 16'(sc[o] + nk[o]))));
            nk[o]++;
        end

        // short request from requester 1: two words then drop
        st = wq.size();
        @(posedge wr_clk); #1 req = 4'b0010;
        @(posedge wr_clk); #2;
        chk("short_owner", 32'(owner), 1);
        chk("short_ack1",  32'(ack),   32'b0010);
        @(posedge wr_clk); #2;
        chk("short_ack2",  32'(ack),   32'b0010);
        @(posedge wr_clk); #1 req = '0;
        #1;
        chk("short_drop_busy",  32'(busy),  1);
        chk("short_drop_wr_en", 32'(wr_en), 0);
        chk("short_drop_ack",   32'(ack),   0);
        @(posedge wr_clk); #2;
        chk("short_idle", 32'(busy), 0);
        chk("short_count", 32'(wq.size() - st), 2);

        // last_owner=1, so search starts at 2; then full for 5 cycles mid-burst
        st = wq.size();
        sc[2] = cnt[2];
        @(posedge wr_clk); #1 req = 4'b0111;
        @(posedge wr_clk); #2;
        chk("full_owner", 32'(owner), 2);
        chk("full_ack1",  32'(ack),   32'b0100);
        @(posedge wr_clk); #2;
        chk("full_wr_en2", 32'(wr_en), 1);
        for (int s = 0; s < 5; s++) begin
            @(posedge wr_clk);
            #1 full = 1'b1;
            #1;
            chk("stall_wr_en", 32'(wr_en), 0);
            chk("stall_ack",   32'(ack),   0);
            chk("stall_busy",  32'(busy),  1);
            chk("stall_owner", 32'(owner), 2);
        end
        @(posedge wr_clk); #1 full = 1'b0;
        #1;
        chk("resume_wr_en3", 32'(wr_en), 1);
        @(posedge wr_clk); #2;
        chk("resume_wr_en4", 32'(wr_en), 1);
        @(posedge wr_clk); #1 req = '0;
        #1;
        chk("full_end_busy", 32'(busy), 0);
        chk("full_count", 32'(wq.size() - st), 4);
        for (int k = 0; k < 4 && st + k < wq.size(); k++) begin
            chk("full_word_owner", 32'(oq[st+k]), 2);
            chk("full_word_data",  32'(wq[st+k]), 32'(16'(16'hA000 + 16'(sc[2] + k))));
        end
        chk("full_overrun", 32'(ovf), 0);

        // reset after the 2nd word of a grant to requester 2
        st = wq.size();
        @(posedge wr_clk); #1 req = 4'b0100;
        @(posedge wr_clk); #2;
        chk("mid_owner", 32'(owner), 2);
        chk("mid_wr_en1", 32'(wr_en), 1);
        @(posedge wr_clk); #2;
        chk("mid_wr_en2", 32'(wr_en), 1);
        @(posedge wr_clk); #1 rst = 1'b1;
        #1;
        chk("mid_rst_wr_en", 32'(wr_en), 0);
        chk("mid_rst_ack",   32'(ack),   0);
        chk("mid_rst_busy",  32'(busy),  0);
        chk("mid_rst_owner", 32'(owner), 0);
        chk("mid_count", 32'(wq.size() - st), 2);
        repeat (2) @(posedge wr_clk);
        #1 rst = 1'b0; req = 4'b0101;
        @(posedge wr_clk); #2;
        chk("post_rst_busy",  32'(busy),  1);
        chk("post_rst_owner", 32'(owner), 0);
        chk("post_rst_ack",   32'(ack),   32'b0001);
        req = '0;
        repeat (3) @(posedge wr_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the write side of `asynchronous_fifo` between `NUM_REQ` requesters in the write clock domain. It grants one requester at a time for a burst of up to `MAX_BURST` words. It drives the FIFO `wr_en`/`din` and honours `full` so the FIFO can never be overrun. It is transparent to the read domain and sits directly in front of the FIFO write port.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `FIFO_DATAWIDTH`, default 16: word width, equal to the FIFO's width.
- `MAX_BURST`, default 4: maximum words per grant, range 1..16.

Ports:
- `wr_clk`, input, 1: the single clock; the FIFO write clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `req`, input, `NUM_REQ`: per-requester "word available" flags; held high while data is pending.
- `req_data`, input, `NUM_REQ*FIFO_DATAWIDTH`: requester *i* owns bits `[i*FIFO_DATAWIDTH +: FIFO_DATAWIDTH]`.
- `ack`, output, `NUM_REQ`: one-hot word-accepted strobe. A requester presents its next word or drops `req` in the cycle after its `ack`.
- `full`, input, 1: FIFO full flag.
- `wr_en`, output, 1: FIFO write enable.
- `din`, output, `FIFO_DATAWIDTH`: FIFO write data.
- `busy`, output, 1: high while in GRANT.
- `owner`, output, `max(1,$clog2(NUM_REQ))`: index of the current or last grantee.

## Operation

Registered state:
- FSM state: IDLE or GRANT.
- `owner`.
- `last_owner`.
- `burst_cnt`: `$clog2(MAX_BURST)+1` bits.

Combinational outputs, decoded from registered state:
- `wr_en = (state==GRANT) && req[owner] && !full`.
- `din = req_data` slice selected by `owner`. It is driven even when `wr_en` is 0.
- `ack[i] = wr_en && (owner==i)`.
- `busy = (state==GRANT)`.

IDLE:
- If `req` is nonzero, select the first set bit searching cyclically from `last_owner+1`. The search wraps from `NUM_REQ-1` to 0.
- Load `owner`, clear `burst_cnt`, go to GRANT.
- If `req` is zero, stay in IDLE.

GRANT, evaluated each cycle:
- Accepted word (`wr_en`=1) with `burst_cnt==MAX_BURST-1`: set `last_owner=owner` and go to IDLE (burst exhausted).
- Accepted word otherwise: `burst_cnt++` and stay.
- `req[owner]`=0: set `last_owner=owner` and go to IDLE. No word is written and no `ack` is issued.
- `req[owner]`=1 and `full`=1: stall and stay. `burst_cnt` is frozen and no `ack` is issued. A stall never ends the grant.

Other rules:
- Requests from non-owners are ignored during GRANT. They wait for the next IDLE arbitration.
- A requester that drops and reasserts `req` within the same grant is served again, provided the grant has not ended.

## Timing

- Reset values (asynchronous, applied immediately): state IDLE, `owner`=0, `last_owner`=`NUM_REQ-1` so requester 0 has first priority, `burst_cnt`=0. Resulting outputs: `wr_en`=0, `ack`=0, `busy`=0. `din` shows requester 0's data.
- Arbitration latency: `req` seen in IDLE at edge N puts the FSM in GRANT after N. The first `wr_en`/`ack` is therefore possible in cycle N+1.
- Throughput:
  - Back-to-back words within a burst, one per cycle.
  - One IDLE bubble cycle between grants.
  - Sustained rate with all requesters active is `MAX_BURST/(MAX_BURST+1)`.
- `full` is used combinationally in the same cycle. A write is never issued while `full`=1, so overflow is impossible regardless of pointer-sync latency.
- Reset asserted mid-burst: the grant is abandoned immediately and `wr_en` drops asynchronously. No partial state survives.
- `MAX_BURST`=1: every accepted word returns the FSM to IDLE, giving strict per-word round-robin.
- Fairness: while continuously requesting, requester *i* waits at most `(NUM_REQ-1)*(MAX_BURST+1)` cycles plus full stalls.

## Test plan

- **Reset and idle.** Hold `rst`=1 for 10 cycles, then release with `req`=0. Required: `wr_en`=0, `ack`=0, `busy`=0, `owner`=0 for 20 cycles.
- **Single requester burst.** `req`=4'b0100 held, data 0xA000..0xA007. Required:
  - `wr_en` runs 4 cycles with `ack`=4'b0100.
  - Then one IDLE cycle, then 4 more cycles.
  - The FIFO receives 0xA000..0xA007 in order.
- **Round-robin rotation.** `req`=4'b1111 held, with distinct data per requester. Required:
  - Grant order is 0,1,2,3,0.
  - Each grant writes exactly 4 words.
  - `owner` changes only across IDLE cycles.
- **Short request.** Requester 1 asserts `req` for 2 words only. Required:
  - Exactly 2 acks.
  - Return to IDLE on the cycle after `req` drops.
  - `last_owner`=1, so the next grant searches from 2.
- **Full backpressure.** Hold `full`=1 for 5 cycles mid-burst. Required:
  - `wr_en`=0 and `ack`=0 for those cycles, with `burst_cnt` frozen.
  - After release the burst resumes and totals 4 words.
  - Against the real FIFO, no write occurs while `full`, and read-back matches write order.
- **Reset mid-burst.** Assert `rst` after the 2nd word of a grant to requester 2. Required:
  - `wr_en` drops immediately.
  - After release, with `req`=4'b0101, requester 0 is granted first.
